keccak_absorb_ctrl: RTL and testbench

Sequencer for the Keccak absorb phase. Accepts a message length in bits plus a stream of 64-bit message words, tracks the bits still to absorb with an internal size counter, and emits rate-lane writes toward the state XOR datapath. Applies SHA-3 multi-rate padding on the final block and hands each full rate block to the permutation core with a start/done handshake. Sits between the input FIFO and the Keccak round core.

---
 rtl/keccak_pkg.sv | 15 +
 rtl/keccak_absorb_ctrl_len_counter.sv | 23 ++
 rtl/keccak_absorb_ctrl.sv | 136 +++++++++++++
 tb/tb_keccak_absorb_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared types and constants for the Keccak absorb controller
package keccak_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD,
        S_FILL,
        S_PERM,
        S_DONE
    } absorb_state_e;
    localparam logic [7:0] DOMAIN_SHA3 = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
    localparam logic [63:0] FINAL_BIT = 64'h8000_0000_0000_0000;
    localparam int RATE_WORDS_DEF = 17;
endpackage

// File: rtl/keccak_absorb_ctrl_len_counter.sv
// absorb_len_counter: bits-remaining counter with load, clear and decrement-by-64
module absorb_len_counter #(
    parameter int SIZE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [SIZE_W-1:0] load_val_i,
    input  logic              dec_i,
    input  logic              clr_i,
    output logic [5:0]        rem_low_o,
    output logic              lt64_o
);
    logic [SIZE_W-1:0] rem_q;
    // Remaining-bit count; decrement is only requested while rem_q >= 64
    always_ff @(posedge clk) begin
        if (rst || clr_i) rem_q <= '0;
        else if (load_i) rem_q <= load_val_i;
        else if (dec_i) rem_q <= rem_q - SIZE_W'(64);
    end
    assign rem_low_o = rem_q[5:0];
    assign lt64_o = rem_q < SIZE_W'(64);
endmodule

// File: rtl/keccak_absorb_ctrl.sv
// keccak_absorb_ctrl: absorb-phase sequencer with SHA-3 padding; KECCAK_SHAKE_EN adds shake_mode domain select
module keccak_absorb_ctrl
    import keccak_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int RATE_WORDS = RATE_WORDS_DEF,
    parameter int SIZE_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SIZE_W-1:0]             size_in,
    input  logic                          size_valid,
    output logic                          size_ready,
`ifdef KECCAK_SHAKE_EN
    input  logic                          shake_mode,
`endif
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          absorb_we,
    output logic [$clog2(RATE_WORDS)-1:0] absorb_idx,
    output logic [WORD_W-1:0]             absorb_data,
    output logic                          perm_start,
    input  logic                          perm_done,
    output logic                          busy,
    output logic                          done
);
    localparam int IDX_W = $clog2(RATE_WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(RATE_WORDS - 1);

    absorb_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             padded_q, padded_d;
    logic             perm_start_q, perm_start_d;
    logic [7:0]       dom_q;
    logic             load, dec, clr, lt64, last, size_hs, blk_end;
    logic [5:0]       rem_low;
    logic [2:0]       b;
    logic [WORD_W-1:0] fin, keep, pad_lane, lane;

    absorb_len_counter #(.SIZE_W(SIZE_W)) u_len (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i ({size_in[SIZE_W-1:3], 3'b000}),
        .dec_i      (dec),
        .clr_i      (clr),
        .rem_low_o  (rem_low),
        .lt64_o     (lt64)
    );

    assign size_hs = state_q == S_IDLE && size_valid;

`ifdef KECCAK_SHAKE_EN
    // Domain byte is latched with the length so it holds for the whole message
    always_ff @(posedge clk) begin
        if (rst) dom_q <= DOMAIN_SHA3;
        else if (size_hs) dom_q <= shake_mode ? DOMAIN_SHAKE : DOMAIN_SHA3;
    end
`else
    assign dom_q = DOMAIN_SHA3;
`endif

    assign b = rem_low[5:3];
    assign last = idx_q == LAST;
    assign size_ready = state_q == S_IDLE;
    assign busy = state_q != S_IDLE;
    assign done = state_q == S_DONE;
    assign perm_start = perm_start_q;
    assign absorb_idx = idx_q;
    assign blk_end = absorb_we && last;

    // Handshake and lane-write strobes; the pad lane with no data bytes needs no input
    always_comb begin
        in_ready = (state_q == S_ABSORB && !lt64) || (state_q == S_PAD && b != 3'd0);
        absorb_we = (state_q == S_ABSORB && !lt64 && in_valid) ||
                    (state_q == S_PAD && (b == 3'd0 || in_valid)) ||
                    state_q == S_FILL;
    end

    // Lane data: raw word, pad lane (data bytes, domain byte, zeros) or fill zeros, plus final bit on the last lane
    always_comb begin
        fin = last ? FINAL_BIT : '0;
        keep = ~({WORD_W{1'b1}} << {b, 3'b000});
        pad_lane = (in_data & keep) | (WORD_W'(dom_q) << {b, 3'b000}) | fin;
        lane = state_q == S_ABSORB ? in_data : state_q == S_PAD ? pad_lane : fin;
        absorb_data = absorb_we ? lane : '0;
    end

    // Next-state, lane index and padding bookkeeping
    always_comb begin
        state_d = state_q;
        idx_d = absorb_we ? (last ? '0 : idx_q + 1'b1) : idx_q;
        padded_d = padded_q;
        perm_start_d = blk_end;
        load = 1'b0;
        dec = 1'b0;
        clr = 1'b0;
        case (state_q)
            S_IDLE: if (size_valid) begin
                load = 1'b1;
                idx_d = '0;
                padded_d = 1'b0;
                state_d = S_ABSORB;
            end
            S_ABSORB: begin
                dec = absorb_we;
                state_d = lt64 ? S_PAD : blk_end ? S_PERM : S_ABSORB;
            end
            S_PAD: if (absorb_we) begin
                clr = 1'b1;
                padded_d = 1'b1;
                state_d = last ? S_PERM : S_FILL;
            end
            S_FILL: state_d = last ? S_PERM : S_FILL;
            S_PERM: if (perm_done) state_d = padded_q ? S_DONE : S_ABSORB;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q <= '0;
            padded_q <= 1'b0;
            perm_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            padded_q <= padded_d;
            perm_start_q <= perm_start_d;
        end
    end
endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// tb_keccak_absorb_ctrl: scoreboard bench for the Keccak absorb controller
module tb_keccak_absorb_ctrl;
    localparam logic [63:0] FIN = 64'h8000_0000_0000_0000;

    typedef struct {
        int          kind;
        int          idx;
        logic [63:0] data;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] size_in = 0;
    logic        size_valid = 0;
    logic        size_ready;
    logic [63:0] in_data = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic        absorb_we;
    logic [4:0]  absorb_idx;
    logic [63:0] absorb_data;
    logic        perm_start;
    logic        perm_done = 0;
    logic        busy;
    logic        done;
`ifdef KECCAK_SHAKE_EN
    logic        shake_mode = 0;
`endif

    int   tests = 0, fails = 0, perm_cnt = 0, done_cnt = 0, viol = 0, perm_delay = 2;
    bit   in_perm = 0;
    exp_t q[$];

    keccak_absorb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .size_in    (size_in),
        .size_valid (size_valid),
        .size_ready (size_ready),
`ifdef KECCAK_SHAKE_EN
        .shake_mode (shake_mode),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .absorb_we  (absorb_we),
        .absorb_idx (absorb_idx),
        .absorb_data(absorb_data),
        .perm_start (perm_start),
        .perm_done  (perm_done),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(int kind, int idx, logic [63:0] data);
        exp_t e;
        e.kind = kind;
        e.idx = idx;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic push_pad(int start, logic [63:0] pad);
        for (int i = start; i < 17; i++) push(0, i, ((i == start) ? pad : 64'd0) | ((i == 16) ? FIN : 64'd0));
    endtask

    task automatic pop_check(int kind, int idx, logic [63:0] data);
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", 64'(kind), 64'd99);
        end else begin
            e = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (e.kind == 0 && kind == 0) begin
                chk($sformatf("lane_idx%0d", e.idx), 64'(idx), 64'(e.idx));
                chk($sformatf("lane_data%0d", e.idx), data, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (in_perm && (in_ready || absorb_we)) viol++;
            if (perm_done) in_perm = 0;
            if (absorb_we) pop_check(0, int'(absorb_idx), absorb_data);
            if (perm_start) begin
                perm_cnt++;
                in_perm = 1;
                pop_check(1, 0, 0);
            end
            if (done) begin
                done_cnt++;
                pop_check(2, 0, 0);
            end
        end
    end

    always begin
        @(negedge clk);
        if (perm_start && !rst) begin
            repeat (perm_delay) @(posedge clk);
            #1 perm_done = 1;
            @(posedge clk);
            #1 perm_done = 0;
        end
    end

    task automatic start_job(logic [31:0] size);
        int n = 0;
        size_in = size;
        size_valid = 1;
        @(negedge clk);
        while (!size_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!size_ready) chk("size_ready_timeout", 64'(size_ready), 64'd1);
        @(posedge clk);
        #1 size_valid = 0;
    endtask

    task automatic send(logic [63:0] w);
        int n = 0;
        in_data = w;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", 64'(done_cnt != start), 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic job_size0();
        push_pad(0, 64'h06);
        push(1, 0, 0);
        push(2, 0, 0);
        in_data = 64'hDEAD_BEEF_DEAD_BEEF;
        in_valid = 1;
        start_job(32'd0);
        wait_done();
        in_valid = 0;
    endtask

    int pc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_size_ready", 64'(size_ready), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_absorb_we", 64'(absorb_we), 64'd0);
        chk("rst_absorb_idx", 64'(absorb_idx), 64'd0);
        chk("rst_absorb_data", absorb_data, 64'd0);
        chk("rst_perm_start", 64'(perm_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        job_size0();

        push(0, 0, 64'h0123_4567_89AB_CDEF);
        push_pad(1, 64'h06);
        push(1, 0, 0);
        push(2, 0, 0);
        start_job(32'd64);
        send(64'h0123_4567_89AB_CDEF);
        in_valid = 0;
        wait_done();

        pc = perm_cnt;
        for (int i = 0; i < 17; i++) push(0, i, 64'hA000 + 64'(i));
        push(1, 0, 0);
        push_pad(0, 64'h06);
        push(1, 0, 0);
        push(2, 0, 0);
        start_job(32'd1088);
        for (int i = 0; i < 17; i++) send(64'hA000 + 64'(i));
        in_valid = 0;
        wait_done();
        chk("two_perms_1088", 64'(perm_cnt - pc), 64'd2);

        pc = perm_cnt;
        for (int i = 0; i < 16; i++) push(0, i, 64'hB000 + 64'(i));
        push(0, 16, 64'h86FF_FFFF_FFFF_FFFF);
        push(1, 0, 0);
        push(2, 0, 0);
        start_job(32'd1080);
        for (int i = 0; i < 16; i++) send(64'hB000 + 64'(i));
        send(64'h5AFF_FFFF_FFFF_FFFF);
        in_valid = 0;
        wait_done();
        chk("one_perm_1080", 64'(perm_cnt - pc), 64'd1);

        push(0, 0, 64'h0000_0000_0006_7788);
        push_pad(1, 64'd0);
        push(1, 0, 0);
        push(2, 0, 0);
        start_job(32'd20);
        send(64'h1122_3344_5566_7788);
        in_valid = 0;
        wait_done();

        pc = perm_cnt;
        viol = 0;
        perm_delay = 24;
        push(0, 0, 64'hC0);
        push(0, 1, 64'hC1);
        push_pad(2, 64'h06);
        push(1, 0, 0);
        push(2, 0, 0);
        start_job(32'd128);
        send(64'hC0);
        send(64'hC1);
        wait_done();
        in_valid = 0;
        perm_delay = 2;
        chk("perm_quiet", 64'(viol), 64'd0);
        chk("one_perm_delayed", 64'(perm_cnt - pc), 64'd1);

        for (int i = 0; i < 5; i++) push(0, i, 64'hD000 + 64'(i));
        start_job(32'd1088);
        for (int i = 0; i < 5; i++) send(64'hD000 + 64'(i));
        in_valid = 0;
        chk("mid_queue_drained", 64'(q.size()), 64'd0);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("mid_rst_size_ready", 64'(size_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_idx", 64'(absorb_idx), 64'd0);
        chk("mid_rst_we", 64'(absorb_we), 64'd0);

        job_size0();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
